// File: rtl/toggle_bank.sv
// toggle_bank: bank of debounced push buttons driving per-channel
// toggle state, either independently or as a radio-select group.
module toggle_bank #(
  parameter int CHANNELS = 4,
  parameter int DEBOUNCE = 2
) (
  input  logic                          clk_1HZ,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           transpush,
  input  logic                          mode,
  input  logic                          clr_all,
  output logic [CHANNELS-1:0]           sequen,
  output logic [CHANNELS-1:0]           led,
  output logic [$clog2(CHANNELS+1)-1:0] active_cnt,
  output logic                          changed
);
  localparam int CW = $clog2(CHANNELS+1);

  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] deb_q;
  logic [CHANNELS-1:0] deb_d;
  logic [CHANNELS-1:0] deb_prev_q;
  logic [7:0]          run_q [CHANNELS];
  logic [7:0]          run_d [CHANNELS];
  logic [CHANNELS-1:0] press;
  logic [CHANNELS-1:0] sel;
  logic [CHANNELS-1:0] seq_q;
  logic [CHANNELS-1:0] seq_d;
  logic [CHANNELS-1:0] led_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic                chg_q;
  logic                chg_d;

  function automatic logic [CW-1:0] popcnt(
    input logic [CHANNELS-1:0] v
  );
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < CHANNELS; i++)
      n = n + CW'(v[i]);
    return n;
  endfunction

  // Level flips once the synced input has disagreed for DEBOUNCE cycles.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < CHANNELS; i++) begin
      run_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if ({1'b0, run_q[i]} + 9'd1 == 9'(DEBOUNCE))
          deb_d[i] = ~deb_q[i];
        else
          run_d[i] = run_q[i] + 8'd1;
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;
  assign sel   = press & (~press + CHANNELS'(1));

  always_comb begin
    seq_d = seq_q;
    if (clr_all) begin
      seq_d = '0;
    end else if (|press) begin
      if (!mode)
        seq_d = seq_q ^ press;
      else if (|(seq_q & sel))
        seq_d = '0;
      else
        seq_d = sel;
    end else if (mode && popcnt(seq_q) > CW'(1)) begin
      // Radio mode keeps only the lowest set bit.
      seq_d = seq_q & (~seq_q + CHANNELS'(1));
    end
    cnt_d = popcnt(seq_d);
    chg_d = seq_d != seq_q;
  end

  always_ff @(posedge clk_1HZ or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < CHANNELS; i++)
        run_q[i] <= '0;
      seq_q      <= '0;
      led_q      <= '0;
      cnt_q      <= '0;
      chg_q      <= 1'b0;
    end else begin
      sync1_q    <= transpush;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      run_q      <= run_d;
      seq_q      <= seq_d;
      led_q      <= seq_d;
      cnt_q      <= cnt_d;
      chg_q      <= chg_d;
    end
  end

  assign sequen     = seq_q;
  assign led        = led_q;
  assign active_cnt = cnt_q;
  assign changed    = chg_q;

endmodule

// File: tb/tb_toggle_bank.sv
// tb_toggle_bank: directed vector table, reset sequence and
// randomized run against a behavioural model of toggle_bank.
module tb_toggle_bank;
  localparam int N = 4;
  localparam int D = 2;

  logic         clk_1HZ;
  logic         rst;
  logic [N-1:0] transpush;
  logic         mode;
  logic         clr_all;
  logic [N-1:0] sequen;
  logic [N-1:0] led;
  logic [2:0]   active_cnt;
  logic         changed;

  toggle_bank #(.CHANNELS(N), .DEBOUNCE(D)) dut (
    .clk_1HZ    (clk_1HZ),
    .rst        (rst),
    .transpush  (transpush),
    .mode       (mode),
    .clr_all    (clr_all),
    .sequen     (sequen),
    .led        (led),
    .active_cnt (active_cnt),
    .changed    (changed)
  );

  initial begin
    clk_1HZ = 1'b0;
    forever #5 clk_1HZ = ~clk_1HZ;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: sync = input seen two edges ago, level flips
  // after D disagreeing cycles, a press is a rising debounced level.
  bit [N-1:0] m_s1, m_s2, m_seq, m_nxt;
  bit         m_deb [N];
  bit         m_dprev [N];
  int         m_run [N];
  bit         m_chg;
  int         m_low;

  always @(posedge clk_1HZ or negedge rst) begin
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_seq = '0; m_chg = 0;
      for (int i = 0; i < N; i++) begin
        m_deb[i] = 0; m_dprev[i] = 0; m_run[i] = 0;
      end
    end else begin
      m_nxt = m_seq;
      m_low = -1;
      for (int i = N-1; i >= 0; i--)
        if (m_deb[i] && !m_dprev[i]) m_low = i;
      if (clr_all) begin
        m_nxt = '0;
      end else if (m_low >= 0) begin
        if (!mode) begin
          for (int i = 0; i < N; i++)
            if (m_deb[i] && !m_dprev[i]) m_nxt[i] = !m_nxt[i];
        end else begin
          m_nxt = m_seq[m_low] ? '0 : N'(1 << m_low);
        end
      end else if (mode && $countones(m_seq) > 1) begin
        for (int i = N-1; i >= 0; i--)
          if (m_seq[i]) m_low = i;
        m_nxt = N'(1 << m_low);
      end
      m_chg = (m_nxt != m_seq);
      m_seq = m_nxt;
      for (int i = 0; i < N; i++) begin
        m_dprev[i] = m_deb[i];
        if (m_s2[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_deb[i] = !m_deb[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = transpush;
    end
  end

  typedef struct {
    logic [N-1:0] tp;
    logic         md;
    logic         clr;
    int           hold;
    logic [N-1:0] seq;
    logic         chg;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic [N-1:0] tp, input logic md,
                     input logic clr, input int hold,
                     input logic [N-1:0] seq, input logic chg);
    vec_t v;
    v.tp = tp; v.md = md; v.clr = clr; v.hold = hold;
    v.seq = seq; v.chg = chg;
    vt.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    transpush = '0;
    mode = 1'b0;
    clr_all = 1'b0;

    // press ch1, hold 10, release, press again
    add(4'b0010, 0, 0, 5, 4'b0010, 1);
    add(4'b0010, 0, 0, 1, 4'b0010, 0);
    add(4'b0010, 0, 0, 4, 4'b0010, 0);
    add(4'b0000, 0, 0, 6, 4'b0010, 0);
    add(4'b0010, 0, 0, 5, 4'b0000, 1);
    add(4'b0000, 0, 0, 6, 4'b0000, 0);
    // one-cycle glitch
    add(4'b0001, 0, 0, 1, 4'b0000, 0);
    add(4'b0000, 0, 0, 6, 4'b0000, 0);
    // radio mode
    add(4'b0000, 1, 0, 2, 4'b0000, 0);
    add(4'b0100, 1, 0, 5, 4'b0100, 1);
    add(4'b0000, 1, 0, 6, 4'b0100, 0);
    add(4'b0001, 1, 0, 5, 4'b0001, 1);
    add(4'b0000, 1, 0, 6, 4'b0001, 0);
    add(4'b0001, 1, 0, 5, 4'b0000, 1);
    add(4'b0000, 1, 0, 6, 4'b0000, 0);
    add(4'b1010, 1, 0, 5, 4'b0010, 1);
    add(4'b0000, 1, 0, 6, 4'b0010, 0);
    // build 1011 then switch to radio
    add(4'b0000, 0, 0, 2, 4'b0010, 0);
    add(4'b1001, 0, 0, 5, 4'b1011, 1);
    add(4'b0000, 0, 0, 6, 4'b1011, 0);
    add(4'b0000, 1, 0, 1, 4'b0001, 1);
    add(4'b0000, 1, 0, 1, 4'b0001, 0);
    // clear collides with a press
    add(4'b0100, 0, 0, 4, 4'b0001, 0);
    add(4'b0100, 0, 1, 1, 4'b0000, 1);
    add(4'b0100, 0, 0, 3, 4'b0000, 0);
    add(4'b0000, 0, 0, 6, 4'b0000, 0);

    #3;
    chk("rst_seq", sequen, 0);
    chk("rst_led", led, 0);
    chk("rst_cnt", active_cnt, 0);
    chk("rst_chg", changed, 0);
    @(posedge clk_1HZ); #1;
    rst = 1'b1;

    for (int k = 0; k < vt.size(); k++) begin
      transpush = vt[k].tp;
      mode = vt[k].md;
      clr_all = vt[k].clr;
      repeat (vt[k].hold) @(posedge clk_1HZ);
      #1;
      chk($sformatf("vec%0d_seq", k), sequen, vt[k].seq);
      chk($sformatf("vec%0d_led", k), led, vt[k].seq);
      chk($sformatf("vec%0d_cnt", k), active_cnt,
          $countones(vt[k].seq));
      chk($sformatf("vec%0d_chg", k), changed, vt[k].chg);
    end

    // async reset during a pending debounce
    transpush = 4'b0110;
    repeat (5) @(posedge clk_1HZ);
    #1;
    chk("pre_rst_seq", sequen, 4'b0110);
    transpush = 4'b0000;
    repeat (6) @(posedge clk_1HZ);
    #1;
    transpush = 4'b1000;
    repeat (3) @(posedge clk_1HZ);
    #2;
    rst = 1'b0;
    #1;
    chk("async_seq", sequen, 0);
    chk("async_led", led, 0);
    chk("async_cnt", active_cnt, 0);
    chk("async_chg", changed, 0);
    @(posedge clk_1HZ); #1;
    rst = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk_1HZ); #1;
      chk($sformatf("held_e%0d_seq", e), sequen,
          (e == 5) ? 4'b1000 : 4'b0000);
      chk($sformatf("held_e%0d_chg", e), changed, (e == 5));
    end
    transpush = 4'b0000;
    repeat (6) @(posedge clk_1HZ);
    #1;

    // randomized run against the model
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk_1HZ); #1;
      chk("rnd_seq", sequen, m_seq);
      chk("rnd_led", led, m_seq);
      chk("rnd_cnt", active_cnt, $countones(m_seq));
      chk("rnd_chg", changed, m_chg);
      if (!rst) rst = 1'b1;
      else if ($urandom_range(299) == 0) rst = 1'b0;
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) transpush[i] = ~transpush[i];
      if ($urandom_range(49) == 0) mode = ~mode;
      clr_all = ($urandom_range(39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
